xoodyak_op_sequencer: RTL and testbench
=======================================

// Module: xoodyak_op_sequencer
// PURPOSE
//  Command scheduler in front of xoodyak_build. Queues host commands (opmode + 352b data) in a FIFO.
//  Issues them one at a time to the core and holds opmode/data stable until the core pulses finished.
//  Returns crypt/decrypt/squeeze text through a valid/ready result port.
//  Enforces session ordering (initialize first), inserts idle gaps between ops and times out a hung core.
// PARAMETERS
//  DEPTH    4    command FIFO entries (power of 2, >=2)
//  TIMEOUT  64   max cycles in ISSUE waiting for core_finished before abort (>=2)
//  GAP      1    cycles core_opmode is forced to 0 between ops (0 = no gap)
//  DW       352  command/core data width
//  TW       192  core text width
// PORTS
//  eph1          in   1           clock, all flops rising edge
//  reset_n       in   1           asynchronous, active-low reset
//  cmd_valid     in   1           command offered
//  cmd_ready     out  1           FIFO not full; push on cmd_valid&cmd_ready
//  cmd_opmode    in   5           [4]=continue, [3]=pass-through, [2:0]=op: 0 idle,1 init,2 nonce,3 assoc,4 crypt,5 decrypt,6 squeeze,7 ratchet
//  cmd_data      in   DW          command payload
//  core_opmode   out  5           registered opmode to xoodyak_build
//  core_data     out  DW          registered input_data to xoodyak_build
//  core_finished in   1           single-cycle done pulse from core
//  core_textout  in   TW          core text, valid in the core_finished cycle
//  res_valid     out  1           result held
//  res_ready     in   1           result consumed on res_valid&res_ready
//  res_text      out  TW          captured text
//  res_op        out  3           op code that produced res_text
//  busy          out  1           state != IDLE or FIFO non-empty
//  fifo_count    out  $clog2(DEPTH+1)  queued entries
//  err_seq       out  1           sticky: op 2..7 received with no open session
//  err_timeout   out  1           sticky: TIMEOUT expired
//  err_clr       in   1           clears both sticky errors (same-cycle new error wins)
// BEHAVIOUR
//  Reset (async, any state): FIFO emptied; session closed; state IDLE.
//   All outputs are 0 except cmd_ready=1.
//  FIFO: circular, wrap-around pointers. Push and pop in the same cycle are both legal; count unchanged.
//   cmd_ready=0 when count==DEPTH; push ignored while full.
//  FSM IDLE/ISSUE/RESULT/GAP:
//   IDLE, FIFO non-empty: pop head on this edge.
//    op==0: no-op, stay IDLE.
//    op in 2..7 and session closed: drop entry, set err_seq, stay IDLE.
//    Otherwise: load core_opmode=cmd_opmode (all 5 bits) and core_data; ->ISSUE. op==1 opens the session.
//   ISSUE: hold core_opmode/core_data; timer counts from 1.
//    core_finished & op in {4,5,6}: capture core_textout->res_text, op->res_op, res_valid=1; ->RESULT.
//    core_finished, other ops: ->GAP.
//    Timer==TIMEOUT with no finished: set err_timeout, close session; ->GAP.
//    A finished pulse in the TIMEOUT cycle counts as success.
//   RESULT: core_opmode=0. On res_valid&res_ready: res_valid=0; ->GAP. No new op issues while a result is held.
//   GAP: core_opmode=0, core_data=0 for GAP cycles; ->IDLE. With GAP=0, RESULT/ISSUE go directly to IDLE.
//  Latency: a push into an empty FIFO while IDLE drives core_opmode 2 edges later (push edge, pop edge).
//  core_finished outside ISSUE: ignored.
//  Session stays open across ops; only reset or timeout close it. op 1 re-initializes while open.
// TESTING
//  Reset, push init(1,key) -> core_opmode=5'h01 2 edges later; held until finished; core_opmode=0 for 1 cycle; busy drops.
//  init, nonce(2), assoc(3), crypt(4): finished with textout=192'h4d4e..4b4c -> res_valid, res_op=4, text held until res_ready.
//  Nonce(2) as first command after reset -> err_seq=1; core_opmode stays 0; entry dropped; err_clr clears.
//  Push 5 cmds with DEPTH=4 and core stalled -> cmd_ready=0 at count 4; 5th push blocked; pointers wrap correctly after drain.
//  init, then no core_finished for 64 cycles -> err_timeout=1, core_opmode=0, session closed; next assoc(3) -> err_seq.
//  Assert reset_n low mid-ISSUE with full FIFO -> outputs cleared immediately (async); FIFO empty after release.

Source files
------------

// File: rtl/xoodyak_op_sequencer.sv
// Command scheduler for xoodyak_build. It queues host commands, issues them to the core one
// at a time, returns text results over a valid/ready port, enforces session ordering and
// times out a core that never finishes.
module xoodyak_op_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 1,
  parameter int unsigned DW      = 352,
  parameter int unsigned TW      = 192
) (
  input  logic                       eph1,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_opmode,
  input  logic [DW-1:0]              cmd_data,
  output logic [4:0]                 core_opmode,
  output logic [DW-1:0]              core_data,
  input  logic                       core_finished,
  input  logic [TW-1:0]              core_textout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TW-1:0]              res_text,
  output logic [2:0]                 res_op,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       err_seq,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned TMW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResult, StGap} state_e;

  state_e state_q, state_d;

  logic [4:0]    op_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]     core_opmode_q, core_opmode_d;
  logic [DW-1:0]  core_data_q, core_data_d;
  logic [TMW-1:0] timer_q, timer_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           session_q, session_d;
  logic           res_valid_q, res_valid_d;
  logic [TW-1:0]  res_text_q, res_text_d;
  logic [2:0]     res_op_q, res_op_d;
  logic           err_seq_q, err_seq_d;
  logic           err_to_q, err_to_d;

  logic       push, pop, issue, seq_bad, timeout_hit, text_op;
  logic [2:0] head_code;
  state_e     post_st;

  assign cmd_ready   = (count_q != CW'(DEPTH));
  assign push        = cmd_valid & cmd_ready;
  assign pop         = (state_q == StIdle) && (count_q != '0);
  assign head_code   = op_mem[rd_ptr_q][2:0];
  // Ops other than idle/init need an open session; bad ones are dropped at pop.
  assign seq_bad     = (head_code > 3'd1) && !session_q;
  assign issue       = pop && (head_code != 3'd0) && !seq_bad;
  assign timeout_hit = (timer_q == TMW'(TIMEOUT));
  assign text_op     = (core_opmode_q[2:0] inside {3'd4, 3'd5, 3'd6});
  assign post_st     = (GAP == 0) ? StIdle : StGap;

  // Payload storage; pointers and count carry the reset.
  always_ff @(posedge eph1) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= cmd_opmode;
      data_mem[wr_ptr_q] <= cmd_data;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      core_opmode_q <= '0;
      core_data_q   <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      session_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_text_q    <= '0;
      res_op_q      <= '0;
      err_seq_q     <= 1'b0;
      err_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q      <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q       <= count_d;
      core_opmode_q <= core_opmode_d;
      core_data_q   <= core_data_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      session_q     <= session_d;
      res_valid_q   <= res_valid_d;
      res_text_q    <= res_text_d;
      res_op_q      <= res_op_d;
      err_seq_q     <= err_seq_d;
      err_to_q      <= err_to_d;
    end
  end

  // FSM next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (issue) state_d = StIssue;
      StIssue: begin
        if (core_finished) state_d = text_op ? StResult : post_st;
        else if (timeout_hit) state_d = post_st;
      end
      StResult: if (res_ready) state_d = post_st;
      StGap:    if (gap_q == GW'(GAP)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered outputs, timers, session and sticky error updates.
  always_comb begin
    core_opmode_d = core_opmode_q;
    core_data_d   = core_data_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    session_d     = session_q;
    res_valid_d   = res_valid_q;
    res_text_d    = res_text_q;
    res_op_d      = res_op_q;
    err_seq_d     = err_seq_q & ~err_clr;
    err_to_d      = err_to_q & ~err_clr;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          core_opmode_d = op_mem[rd_ptr_q];
          core_data_d   = data_mem[rd_ptr_q];
          timer_d       = TMW'(1);
          if (head_code == 3'd1) session_d = 1'b1;
        end
        if (pop && seq_bad) err_seq_d = 1'b1;
      end
      StIssue: begin
        if (core_finished) begin
          core_opmode_d = '0;
          if (text_op) begin
            res_valid_d = 1'b1;
            res_text_d  = core_textout;
            res_op_d    = core_opmode_q[2:0];
          end else begin
            core_data_d = '0;
            gap_d       = GW'(1);
          end
        end else if (timeout_hit) begin
          core_opmode_d = '0;
          core_data_d   = '0;
          gap_d         = GW'(1);
          session_d     = 1'b0;
          err_to_d      = 1'b1;
        end else begin
          timer_d = timer_q + TMW'(1);
        end
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          core_data_d = '0;
          gap_d       = GW'(1);
        end
      end
      StGap:   gap_d = gap_q + GW'(1);
      default: ;
    endcase
  end

  assign core_opmode = core_opmode_q;
  assign core_data   = core_data_q;
  assign res_valid   = res_valid_q;
  assign res_text    = res_text_q;
  assign res_op      = res_op_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);
  assign fifo_count  = count_q;
  assign err_seq     = err_seq_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// Directed bench for xoodyak_op_sequencer: inputs change and outputs are sampled on the
// falling edge, away from the rising active edge.
module tb_xoodyak_op_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 352;
  localparam int unsigned TW    = 192;

  logic          eph1, reset_n;
  logic          cmd_valid, cmd_ready;
  logic [4:0]    cmd_opmode, core_opmode;
  logic [DW-1:0] cmd_data, core_data;
  logic          core_finished;
  logic [TW-1:0] core_textout, res_text;
  logic          res_valid, res_ready;
  logic [2:0]    res_op;
  logic          busy, err_seq, err_timeout, err_clr;
  logic [2:0]    fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  xoodyak_op_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT(64), .GAP(1), .DW(DW), .TW(TW)
  ) dut (
    .eph1(eph1), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opmode(cmd_opmode), .cmd_data(cmd_data),
    .core_opmode(core_opmode), .core_data(core_data), .core_finished(core_finished),
    .core_textout(core_textout),
    .res_valid(res_valid), .res_ready(res_ready), .res_text(res_text), .res_op(res_op),
    .busy(busy), .fifo_count(fifo_count), .err_seq(err_seq), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge eph1);
  endtask

  task automatic push(input logic [4:0] op, input logic [DW-1:0] d);
    cmd_valid  = 1'b1;
    cmd_opmode = op;
    cmd_data   = d;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic finish(input logic [TW-1:0] t);
    core_finished = 1'b1;
    core_textout  = t;
    tick();
    core_finished = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  localparam logic [TW-1:0] Text = 192'h4d4e4f5051525354_55565758595a4142_434445464748_4b4c;
  localparam logic [DW-1:0] Key  = {320'h0, 32'hC0FFEE01};

  logic [4:0]    q_op [4];
  logic [DW-1:0] q_d  [4];

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_opmode = '0; cmd_data = '0;
    core_finished = 1'b0; core_textout = '0; res_ready = 1'b0; err_clr = 1'b0;
    q_op[0] = 5'h02; q_op[1] = 5'h13; q_op[2] = 5'h0a; q_op[3] = 5'h07;
    for (int i = 0; i < 4; i++) q_d[i] = {320'h0, 32'hA0000000 + 32'(i)};

    // Reset values
    tick();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_core_opmode", core_opmode, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_errs", {err_seq, err_timeout}, 0);
    reset_n = 1'b1;

    // Init: two-edge latency, hold, one gap cycle, idle
    push(5'h01, Key);
    check_eq("init_count", fifo_count, 1);
    check_eq("init_not_yet", core_opmode, 0);
    tick();
    check_eq("init_opmode", core_opmode, 5'h01);
    check_eq("init_data", core_data, Key);
    tick(); tick(); tick();
    check_eq("init_hold", core_opmode, 5'h01);
    finish('0);
    check_eq("init_gap_opmode", core_opmode, 0);
    check_eq("init_gap_data", core_data, 0);
    check_eq("init_gap_busy", busy, 1);
    tick();
    check_eq("init_idle_busy", busy, 0);

    // Nonce, assoc, then crypt with a held result
    push(5'h02, {DW{1'b1}}); tick();
    check_eq("nonce_opmode", core_opmode, 5'h02);
    finish('0); tick();
    push(5'h03, 352'h5); tick();
    check_eq("assoc_opmode", core_opmode, 5'h03);
    finish('0); tick();
    push(5'h04, 352'h6); tick();
    check_eq("crypt_opmode", core_opmode, 5'h04);
    finish(Text);
    core_textout = '0;
    check_eq("crypt_res_valid", res_valid, 1);
    check_eq("crypt_res_op", res_op, 4);
    check_eq("crypt_res_text", res_text, Text);
    check_eq("crypt_result_opmode", core_opmode, 0);
    tick(); tick();
    check_eq("crypt_text_held", res_text, Text);
    check_eq("crypt_valid_held", res_valid, 1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    check_eq("crypt_consumed", res_valid, 0);
    tick();
    check_eq("crypt_idle", busy, 0);

    // Nonce with no open session is dropped and flagged
    do_reset();
    push(5'h02, 352'h9); tick();
    check_eq("seq_err", err_seq, 1);
    check_eq("seq_opmode", core_opmode, 0);
    check_eq("seq_dropped", fifo_count, 0);
    tick();
    check_eq("seq_busy", busy, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check_eq("seq_clr", err_seq, 0);

    // Full FIFO behind a stalled core, then drain across the pointer wrap
    do_reset();
    push(5'h01, Key); tick();
    for (int i = 0; i < 4; i++) push(q_op[i], q_d[i]);
    check_eq("full_count", fifo_count, 4);
    check_eq("full_ready", cmd_ready, 0);
    push(5'h06, 352'hdead);
    check_eq("full_blocked", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      finish('0); tick(); tick();
      check_eq($sformatf("drain_op%0d", i), core_opmode, q_op[i]);
      check_eq($sformatf("drain_data%0d", i), core_data, q_d[i]);
    end
    finish('0); tick();
    check_eq("drain_empty", {busy, fifo_count}, 0);
    push(5'h06, 352'hbeef); tick();
    check_eq("wrap_op", core_opmode, 5'h06);
    check_eq("wrap_data", core_data, 352'hbeef);
    finish(Text);
    res_ready = 1'b1; tick(); res_ready = 1'b0; tick();

    // Hung core times out on the 64th ISSUE cycle and closes the session
    do_reset();
    push(5'h01, Key); tick();
    for (int i = 0; i < 63; i++) tick();
    check_eq("to_not_yet", err_timeout, 0);
    check_eq("to_still_held", core_opmode, 5'h01);
    tick();
    check_eq("to_err", err_timeout, 1);
    check_eq("to_opmode", core_opmode, 0);
    tick();
    push(5'h03, 352'h3); tick();
    check_eq("to_session_closed", err_seq, 1);
    check_eq("to_assoc_not_issued", core_opmode, 0);

    // Asynchronous reset mid-ISSUE with a full FIFO
    do_reset();
    push(5'h01, Key); tick();
    for (int i = 0; i < 4; i++) push(q_op[i], q_d[i]);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_opmode", core_opmode, 0);
    check_eq("arst_count", fifo_count, 0);
    check_eq("arst_ready", cmd_ready, 1);
    check_eq("arst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("arst_after_release", {busy, fifo_count, core_opmode}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
